// File: rtl/leb128_stream_dec_if.sv
// Byte-in / word-out handshake bundle for the LEB128 stream decoder.
// The master drives bytes in and accepts words out; the slave is the decoder.
interface leb128_stream_dec_if #(
    parameter int W  = 32,
    parameter int LW = 3
);
    logic [7:0]    i_data;
    logic          i_valid;
    logic          i_ready;
    logic [W-1:0]  o_data;
    logic [LW-1:0] o_len;
    logic          o_err;
    logic          o_valid;
    logic          o_ready;

    modport master (
        output i_data, i_valid, o_ready,
        input  i_ready, o_data, o_len, o_err, o_valid
    );

    modport slave (
        input  i_data, i_valid, o_ready,
        output i_ready, o_data, o_len, o_err, o_valid
    );
endinterface

// File: rtl/leb128_stream_dec.sv
// Byte-serial LEB128 / SLEB128 decoder.
// Accepts one byte per cycle and emits one W-bit word per terminated sequence.
// Overlong sequences are drained in SKIP and reported once with o_err set.
// The output word sits in a single register: a new word can load on the same
// edge the old one is taken, so streaming needs no bubble cycles.
module leb128_stream_dec #(
    parameter int W      = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    leb128_stream_dec_if.slave bus
);
    localparam int MAXB = (W + 6) / 7;
    localparam int LW   = $clog2(MAXB + 1);
    // usable chunk bits in the last legal byte
    localparam int U    = W - 7 * (MAXB - 1);
    // chunk bits that must be zero (unsigned) or all equal (signed) in the last byte
    localparam logic [6:0] HI_U = 7'(7'h7F << U);
    localparam logic [6:0] HI_S = 7'(7'h7F << (U - 1));

    typedef enum logic [0:0] {ST_ACC, ST_SKIP} state_t;

    state_t        state_reg, state_next;
    logic [LW-1:0] k_reg, k_next;
    logic [W-1:0]  acc_reg, acc_next;
    logic          e_reg, e_next;
    logic [W-1:0]  o_data_reg, o_data_next;
    logic [LW-1:0] o_len_reg, o_len_next;
    logic          o_err_reg, o_err_next;
    logic          o_valid_reg, o_valid_next;

    logic          in_ready;
    logic          accept;
    logic          glue;
    logic [6:0]    chunk;
    logic          is_last;
    logic          last_bad;
    logic [6:0]    sval;
    logic [W-1:0]  lane_bits;   // this byte's chunk placed at bit 7k, truncated at W-1
    logic [W-1:0]  above;       // bits strictly above 7k+6, used for sign fill

    assign in_ready = !o_valid_reg || bus.o_ready;
    assign accept   = bus.i_valid && in_ready;
    assign glue     = bus.i_data[7];
    assign chunk    = bus.i_data[6:0];
    assign is_last  = (k_reg == LW'(MAXB - 1));
    assign sval     = chunk & HI_S;
    assign last_bad = is_last && (SIGNED ? ((sval != 7'd0) && (sval != HI_S))
                                         : ((chunk & HI_U) != 7'd0));

    // Per-bit lane decode: each output bit belongs to byte lane gi/7.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_lane
            localparam int LANE = gi / 7;
            localparam int POS  = gi % 7;
            assign lane_bits[gi] = (k_reg == LW'(LANE)) ? chunk[POS] : 1'b0;
            assign above[gi]     = (LW'(LANE) > k_reg);
        end
    endgenerate

    // Next-state and output-register logic for the accumulate/skip FSM.
    always_comb begin
        state_next   = state_reg;
        k_next       = k_reg;
        acc_next     = acc_reg;
        e_next       = e_reg;
        o_data_next  = o_data_reg;
        o_len_next   = o_len_reg;
        o_err_next   = o_err_reg;
        o_valid_next = o_valid_reg;

        if (o_valid_reg && bus.o_ready) begin
            o_valid_next = 1'b0;
        end

        if (accept) begin
            case (state_reg)
                ST_ACC: begin
                    if (!glue) begin
                        o_valid_next = 1'b1;
                        o_data_next  = (acc_reg | lane_bits) |
                                       ((SIGNED && chunk[6]) ? above : '0);
                        o_len_next   = k_reg + LW'(1);
                        o_err_next   = e_reg | last_bad;
                        k_next       = '0;
                        acc_next     = '0;
                        e_next       = 1'b0;
                    end else if (is_last) begin
                        // overlong: keep the first MAXB bytes, drop the rest
                        acc_next   = acc_reg | lane_bits;
                        e_next     = 1'b1;
                        state_next = ST_SKIP;
                    end else begin
                        acc_next = acc_reg | lane_bits;
                        k_next   = k_reg + LW'(1);
                    end
                end
                ST_SKIP: begin
                    if (!glue) begin
                        // all W bits were filled by the first MAXB bytes
                        o_valid_next = 1'b1;
                        o_data_next  = acc_reg;
                        o_len_next   = LW'(MAXB);
                        o_err_next   = 1'b1;
                        k_next       = '0;
                        acc_next     = '0;
                        e_next       = 1'b0;
                        state_next   = ST_ACC;
                    end
                end
                default: state_next = ST_ACC;
            endcase
        end
    end

    // State, accumulator and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_ACC;
            k_reg       <= '0;
            acc_reg     <= '0;
            e_reg       <= 1'b0;
            o_data_reg  <= '0;
            o_len_reg   <= '0;
            o_err_reg   <= 1'b0;
            o_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            k_reg       <= k_next;
            acc_reg     <= acc_next;
            e_reg       <= e_next;
            o_data_reg  <= o_data_next;
            o_len_reg   <= o_len_next;
            o_err_reg   <= o_err_next;
            o_valid_reg <= o_valid_next;
        end
    end

    assign bus.i_ready = in_ready;
    assign bus.o_data  = o_data_reg;
    assign bus.o_len   = o_len_reg;
    assign bus.o_err   = o_err_reg;
    assign bus.o_valid = o_valid_reg;

endmodule

// File: tb/tb_leb128_stream_dec.sv
// Scoreboard bench for leb128_stream_dec: three instances (u32, s32, u64).
// Stimulus pushes expected words into per-instance queues; monitors pop and
// compare whenever an output handshake occurs.
module tb_leb128_stream_dec;
    logic clk;
    logic rst;

    typedef struct {
        logic [63:0] d;
        int          len;
        bit          err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    logic [7:0] bq[$];

    int checks = 0;
    int errors = 0;
    bit bp_done;

    leb128_stream_dec_if #(.W(32), .LW(3)) if0 ();
    leb128_stream_dec_if #(.W(32), .LW(3)) if1 ();
    leb128_stream_dec_if #(.W(64), .LW(4)) if2 ();

    leb128_stream_dec #(.W(32), .SIGNED(1'b0)) u_u32 (.clk(clk), .rst(rst), .bus(if0.slave));
    leb128_stream_dec #(.W(32), .SIGNED(1'b1)) u_s32 (.clk(clk), .rst(rst), .bus(if1.slave));
    leb128_stream_dec #(.W(64), .SIGNED(1'b0)) u_u64 (.clk(clk), .rst(rst), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic mon(input int sel, input logic [63:0] d, input int len, input bit err);
        exp_t e;
        int n;
        n = (sel == 0) ? q0.size() : (sel == 1) ? q1.size() : q2.size();
        if (n == 0) begin
            chk($sformatf("unexpected_out_dut%0d", sel), d, 64'hDEAD_0000_0000_DEAD);
        end else begin
            if (sel == 0) e = q0.pop_front();
            else if (sel == 1) e = q1.pop_front();
            else e = q2.pop_front();
            $display("dut%0d out data=0x%0h len=%0d err=%0d", sel, d, len, err);
            chk($sformatf("dut%0d_data", sel), d, e.d);
            chk($sformatf("dut%0d_len", sel), 64'(len), 64'(e.len));
            chk($sformatf("dut%0d_err", sel), 64'(err), 64'(e.err));
        end
    endtask

    // Monitors: one per instance, sampling on the falling edge.
    always @(negedge clk) if (!rst && if0.o_valid && if0.o_ready) mon(0, 64'(if0.o_data), int'(if0.o_len), if0.o_err);
    always @(negedge clk) if (!rst && if1.o_valid && if1.o_ready) mon(1, 64'(if1.o_data), int'(if1.o_len), if1.o_err);
    always @(negedge clk) if (!rst && if2.o_valid && if2.o_ready) mon(2, 64'(if2.o_data), int'(if2.o_len), if2.o_err);

    task automatic drive(input int sel, input logic [7:0] b, input logic v);
        case (sel)
            0: begin if0.i_data = b; if0.i_valid = v; end
            1: begin if1.i_data = b; if1.i_valid = v; end
            default: begin if2.i_data = b; if2.i_valid = v; end
        endcase
    endtask

    function automatic logic rdy(input int sel);
        case (sel)
            0: return if0.i_ready;
            1: return if1.i_ready;
            default: return if2.i_ready;
        endcase
    endfunction

    task automatic send(input int sel, input logic [7:0] b);
        int  n;
        logic took;
        n = 0;
        took = 1'b0;
        drive(sel, b, 1'b1);
        while (!took) begin
            @(negedge clk);
            took = rdy(sel);
            @(posedge clk);
            #1;
            if (!took) begin
                n++;
                if (n > 200) begin
                    chk("send_timeout", 64'(n), 64'd0);
                    took = 1'b1;
                end
            end
        end
        drive(sel, 8'h00, 1'b0);
    endtask

    task automatic push(input int sel, input logic [63:0] d, input int len, input bit err);
        exp_t e;
        e.d = d;
        e.len = len;
        e.err = err;
        if (sel == 0) q0.push_back(e);
        else if (sel == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    // Send the bytes in bq as one sequence with its expected result.
    task automatic seq(input int sel, input logic [63:0] d, input int len, input bit err);
        push(sel, d, len, err);
        foreach (bq[i]) send(sel, bq[i]);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 8'h00, 1'b0);
        drive(1, 8'h00, 1'b0);
        drive(2, 8'h00, 1'b0);
        if0.o_ready = 1'b1;
        if1.o_ready = 1'b1;
        if2.o_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_o_valid", 64'(if0.o_valid), 64'd0);
        chk("rst_o_data", 64'(if0.o_data), 64'd0);
        chk("rst_o_len", 64'(if0.o_len), 64'd0);
        chk("rst_o_err", 64'(if0.o_err), 64'd0);
        chk("rst_i_ready", 64'(if0.i_ready), 64'd1);
        @(posedge clk);
        #1;

        bq = {8'hE5, 8'h8E, 8'h26};                    seq(0, 64'h0009_8765, 3, 1'b0);
        bq = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};      seq(0, 64'hFFFF_FFFF, 5, 1'b0);
        bq = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F};      seq(0, 64'hFFFF_FFFF, 5, 1'b1);
        bq = {8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00}; seq(0, 64'h0, 5, 1'b1);
        bq = {8'h01};                                   seq(0, 64'h1, 1, 1'b0);

        bq = {8'hC0, 8'hBB, 8'h78};                    seq(1, 64'hFFFE_1DC0, 3, 1'b0);
        bq = {8'h7F};                                   seq(1, 64'hFFFF_FFFF, 1, 1'b0);
        bq = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};      seq(1, 64'hFFFF_FFFF, 5, 1'b0);
        bq = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h4F};      seq(1, 64'hFFFF_FFFF, 5, 1'b1);
        bq = {8'h3F};                                   seq(1, 64'h3F, 1, 1'b0);

        bq = {8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h01};
        seq(2, 64'h8000_0000_0000_0000, 10, 1'b0);

        // backpressure: hold o_ready low while streaming 01 02 03
        repeat (2) @(posedge clk);
        #1;
        if0.o_ready = 1'b0;
        bp_done = 1'b0;
        fork
            begin
                bq = {8'h01}; seq(0, 64'h1, 1, 1'b0);
                bq = {8'h02}; seq(0, 64'h2, 1, 1'b0);
                bq = {8'h03}; seq(0, 64'h3, 1, 1'b0);
                bp_done = 1'b1;
            end
        join_none
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("bp_i_ready", 64'(if0.i_ready), 64'd0);
            chk("bp_o_valid", 64'(if0.o_valid), 64'd1);
            chk("bp_o_data_held", 64'(if0.o_data), 64'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        if0.o_ready = 1'b1;
        for (int i = 0; i < 100 && !bp_done; i++) @(posedge clk);
        chk("bp_done", 64'(bp_done), 64'd1);
        #1;

        // reset mid-sequence drops the partial E5 8E
        send(0, 8'hE5);
        send(0, 8'h8E);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bq = {8'h05}; seq(0, 64'h5, 1, 1'b0);

        repeat (5) @(posedge clk);
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q2_drained", 64'(q2.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/leb128_stream_dec.md
# leb128_stream_dec

Byte-serial LEB128 decoder. It generalises the fixed 5-byte parallel 32-bit unpacker to a configurable output width and an unsigned or signed (SLEB128) mode, and adds valid/ready handshakes and error detection. It sits between a byte-wide stream (for example a wasm section reader) and word consumers. It accepts one byte per cycle and emits one decoded word per terminated LEB128 sequence.

## Interface
- W, 32: decoded output width, 8..64.
- SIGNED, 0: 0 = unsigned LEB128, 1 = signed SLEB128 with sign extension.
- MAXB (derived), ceil(W/7): maximum legal encoded length in bytes; 5 for W=32, 10 for W=64.
- LW (derived), $clog2(MAXB+1): width of the length field.
- clk  in  1  the single clock; all logic is synchronous to its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_data  in  8  input byte; bit 7 is the continuation (glue) bit, bits 6:0 are the chunk.
- i_valid  in  1  i_data is valid.
- i_ready  out  1  byte is accepted this cycle when i_valid && i_ready.
- o_data  out  W  decoded value.
- o_len  out  LW  one-based count of bytes consumed, saturating at MAXB.
- o_err  out  1  sequence was overlong or overflowed W.
- o_valid  out  1  o_data/o_len/o_err are valid.
- o_ready  in  1  consumer accepts the output when o_valid && o_ready.

## Operation
- States:
  - ACC: accumulating; the reset state.
  - SKIP: draining an overlong sequence.
- Internal registers: accumulator acc[W-1:0], byte index k (0..MAXB), error flag e.
- i_ready = !o_valid || o_ready (combinational). No byte is accepted while an undelivered result is held.
- Accepted byte in ACC at index k < MAXB:
  - Chunk bits map to acc[7k+6:7k], truncated at W-1.
  - Last legal byte, k = MAXB-1, has U = W-7(MAXB-1) usable bits.
    - Unsigned: chunk bits 6:U must be 0, else set e.
    - Signed: chunk bits 6:U-1 must all be equal, else set e.
  - Byte with glue bit = 0 terminates the sequence. The output register loads:
    - o_data = acc merged with this chunk.
    - If SIGNED, bits above 7k+6 are filled with chunk bit 6. If unsigned, they are zero.
    - o_len = k+1, o_err = e (including this byte's check), o_valid = 1.
    - k, acc and e clear.
  - Byte with glue bit = 1 and k < MAXB-1: k increments.
  - Byte with glue bit = 1 and k = MAXB-1 (overlong): set e, move to SKIP.
- SKIP:
  - Accepted bytes are discarded.
  - The first byte with glue bit = 0 loads the output with acc from the first MAXB bytes (sign-extended per mode), o_len = MAXB, o_err = 1.
  - The state returns to ACC.
- Output register holds its value, stable, until o_valid && o_ready. On that handshake o_valid clears, unless a terminating byte is accepted in the same cycle, in which case the new result loads.
- Reset values: o_valid = 0, o_data = 0, o_len = 0, o_err = 0, state = ACC, k = 0, acc = 0, e = 0. i_ready = 1 after reset.
- Reset asserted mid-sequence or with o_valid high drops the partial sequence and the pending result. No output is produced for them.

## Timing
- Latency: terminating byte accepted in cycle n gives o_valid = 1 in cycle n+1.
- Throughput: one byte per cycle. A W=32 5-byte value occupies 5 input cycles.
- Back-to-back sequences need no gap cycle.
- When o_ready is held 1, output words stream at the input sequence rate.
- With o_valid = 1 and o_ready = 0: i_ready = 0. Input stalls without loss. acc/k/state are frozen.
- Simultaneous output handshake and terminating input byte: the old word is delivered and the new word is loaded in the same edge. There is no bubble.
- Nothing is combinational from i_data to any output. i_ready depends only on o_valid and o_ready.

## Test plan
- W=32, SIGNED=0, o_ready=1, input bytes E5 8E 26 -> one cycle after 26: o_data=0x00098765 (624485), o_len=3, o_err=0.
- W=32, SIGNED=1, input C0 BB 78 -> o_data=0xFFFE1DC0 (-123456), o_len=3. Then input 7F -> o_data=0xFFFFFFFF, o_len=1.
- W=32, SIGNED=0:
  - Input FF FF FF FF 0F -> o_data=0xFFFFFFFF, o_len=5, o_err=0.
  - Input FF FF FF FF 1F -> o_err=1, o_len=5.
- W=32, SIGNED=0, input 80 80 80 80 80 00 -> 6 bytes accepted, a single output with o_data=0, o_len=5, o_err=1. A following 01 decodes to 1, o_len=1, o_err=0.
- Backpressure: o_ready=0 while streaming 01 02 03.
  - After the first result, i_ready=0 and o_data=1 is held stable.
  - Raising o_ready yields 1, 2, 3 in order. None lost or duplicated.
- W=64, SIGNED=0, input 80 ×9 then 01 -> o_data=0x8000000000000000, o_len=10, o_err=0.
- Reset: input E5 8E, then rst for 1 cycle, then 05 -> o_data=5, o_len=1, o_err=0. No output attributable to E5 8E.
